// File: rtl/memory_access_stage.sv
// memory_access_stage
//
// Memory stage that sits right after execute. It accepts one instruction at a
// time. A pass-through instruction finishes in one cycle. A load or store makes
// exactly one data-cache transaction: a valid/ready request, then a response.
// The result goes to writeback with a one-cycle mem_done pulse. Loads return
// extracted, sign- or zero-extended data. Stores return zero and never write
// a register.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
// A trapped access issues no cache request and completes immediately with
// mem_fault set. Without the macro the mem_fault port does not exist. A
// misaligned access then proceeds with its byte lanes clipped at the
// doubleword boundary.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   mem_enable             start strobe, only looked at while idle
//   alu_result             effective address (load/store) or pass-through value
//   store_data             store source operand
//   is_load, is_store      access type (both high behaves as a load)
//   funct3                 size/sign: B, H, W, D, BU, HU, WU
//   rd_in, reg_write_in    writeback tags carried alongside the access
//   dcache_req_*           request channel (doubleword-aligned address + strobes)
//   dcache_resp_*          response channel (read data or write acknowledge)
//   mem_data_out, rd_out,
//   reg_write_out          registered writeback payload, held between completions
//   mem_done               one-cycle completion pulse
//   mem_busy               high whenever the stage is not idle
//   mem_fault              misalignment trap flag (MEM_MISALIGN_TRAP_EN only)

module memory_access_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_enable,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  output logic            dcache_req_valid,
  input  logic            dcache_req_ready,
  output logic [XLEN-1:0] dcache_req_addr,
  output logic            dcache_req_write,
  output logic [XLEN-1:0] dcache_req_wdata,
  output logic [7:0]      dcache_req_wstrb,
  input  logic            dcache_resp_valid,
  input  logic [XLEN-1:0] dcache_resp_rdata,
  output logic [XLEN-1:0] mem_data_out,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_done,
  output logic            mem_busy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            mem_fault
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state, next_state;

  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_store_data;
  logic            lat_store;
  logic [2:0]      lat_funct3;
  logic [4:0]      lat_rd;
  logic            lat_reg_write;

  logic [2:0]      off;
  logic [XLEN-1:0] shifted_wdata;
  logic [7:0]      shifted_wstrb;
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_value;
  logic            start_access;

  // Strobe pattern for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // An access is misaligned when its address is not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = |a[1:0];
      default: is_misaligned = |a;
    endcase
  endfunction

  logic trap_now;
  assign trap_now = is_misaligned(alu_result[2:0], funct3[1:0]);
`endif

  assign start_access = is_load | is_store;

  // Lane steering works on the latched address. Shifts are done at the
  // doubleword width, so lanes that would fall past byte 7 are dropped.
  assign off           = lat_addr[2:0];
  assign shifted_wdata = lat_store_data << {off, 3'b000};
  assign shifted_wstrb = size_mask(lat_funct3[1:0]) << off;
  assign load_raw      = dcache_resp_rdata >> {off, 3'b000};

  // Truncate to the access size, then sign- or zero-extend. A doubleword load,
  // and the unused encoding 111, pass the whole shifted word.
  always_comb begin
    load_value = load_raw;
    case (lat_funct3)
      3'b000:  load_value = {{56{load_raw[7]}},  load_raw[7:0]};
      3'b001:  load_value = {{48{load_raw[15]}}, load_raw[15:0]};
      3'b010:  load_value = {{32{load_raw[31]}}, load_raw[31:0]};
      3'b100:  load_value = {56'd0, load_raw[7:0]};
      3'b101:  load_value = {48'd0, load_raw[15:0]};
      3'b110:  load_value = {32'd0, load_raw[31:0]};
      default: load_value = load_raw;
    endcase
  end

  // The request fields are driven only in REQ. They come from latched state,
  // so they cannot change while valid waits for ready.
  assign dcache_req_valid = (state == REQ);
  assign dcache_req_addr  = (state == REQ) ? {lat_addr[XLEN-1:3], 3'b000} : '0;
  assign dcache_req_write = (state == REQ) & lat_store;
  assign dcache_req_wdata = (state == REQ) ? shifted_wdata : '0;
  assign dcache_req_wstrb = (state == REQ) ? shifted_wstrb : 8'h00;
  assign mem_done         = (state == DONE);
  assign mem_busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A pass-through, or a trapped misaligned access, skips
  // the cache entirely. A response only matters while in WAIT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_enable) begin
          if (start_access) begin
`ifdef MEM_MISALIGN_TRAP_EN
            next_state = trap_now ? DONE : REQ;
`else
            next_state = REQ;
`endif
          end else begin
            next_state = DONE;
          end
        end
      end
      REQ:     if (dcache_req_ready) next_state = WAIT;
      WAIT:    if (dcache_resp_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Access latch and writeback registers. The writeback outputs change only
  // on the edge that enters DONE, so they hold steady between completions.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr       <= '0;
      lat_store_data <= '0;
      lat_store      <= 1'b0;
      lat_funct3     <= 3'b000;
      lat_rd         <= 5'd0;
      lat_reg_write  <= 1'b0;
      mem_data_out   <= '0;
      rd_out         <= 5'd0;
      reg_write_out  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_fault      <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      mem_fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_enable) begin
            lat_addr       <= alu_result;
            lat_store_data <= store_data;
            lat_store      <= is_store & ~is_load;
            lat_funct3     <= funct3;
            lat_rd         <= rd_in;
            lat_reg_write  <= reg_write_in;
            if (!start_access) begin
              mem_data_out  <= alu_result;
              rd_out        <= rd_in;
              reg_write_out <= reg_write_in;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (trap_now) begin
              mem_fault     <= 1'b1;
              mem_data_out  <= '0;
              rd_out        <= rd_in;
              reg_write_out <= 1'b0;
            end
`endif
          end
        end
        WAIT: begin
          if (dcache_resp_valid) begin
            rd_out <= lat_rd;
            if (lat_store) begin
              mem_data_out  <= '0;
              reg_write_out <= 1'b0;
            end else begin
              mem_data_out  <= load_value;
              reg_write_out <= lat_reg_write;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage
//
// Directed bench for memory_access_stage. It covers reset state, pass-through,
// loads of every size and sign, stores, illegal load+store, backpressure with
// an ignored mid-access start, reset during WAIT, and misaligned accesses
// (either trapped or lane-clipped, depending on MEM_MISALIGN_TRAP_EN).

module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic        mem_enable;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        dcache_req_valid;
  logic        dcache_req_ready;
  logic [63:0] dcache_req_addr;
  logic        dcache_req_write;
  logic [63:0] dcache_req_wdata;
  logic [7:0]  dcache_req_wstrb;
  logic        dcache_resp_valid;
  logic [63:0] dcache_resp_rdata;
  logic [63:0] mem_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_done;
  logic        mem_busy;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_fault;
`endif

  int checks = 0;
  int errors = 0;

  memory_access_stage #(.XLEN(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_enable        (mem_enable),
    .alu_result        (alu_result),
    .store_data        (store_data),
    .is_load           (is_load),
    .is_store          (is_store),
    .funct3            (funct3),
    .rd_in             (rd_in),
    .reg_write_in      (reg_write_in),
    .dcache_req_valid  (dcache_req_valid),
    .dcache_req_ready  (dcache_req_ready),
    .dcache_req_addr   (dcache_req_addr),
    .dcache_req_write  (dcache_req_write),
    .dcache_req_wdata  (dcache_req_wdata),
    .dcache_req_wstrb  (dcache_req_wstrb),
    .dcache_resp_valid (dcache_resp_valid),
    .dcache_resp_rdata (dcache_resp_rdata),
    .mem_data_out      (mem_data_out),
    .rd_out            (rd_out),
    .reg_write_out     (reg_write_out),
    .mem_done          (mem_done),
    .mem_busy          (mem_busy)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .mem_fault         (mem_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one instruction at the current negedge. The cache side is played
  // with the given ready/response delays. Cycle 0 is the enable cycle. The task
  // returns at the negedge of the mem_done cycle, or -1 if no done arrives in
  // time. It also reports the request fields and whether they stayed stable.
  task automatic do_access(
    input  logic [63:0] addr, input logic [63:0] sdata,
    input  logic ld, input logic st, input logic [2:0] f3,
    input  logic [4:0] rd, input logic rw,
    input  int ready_delay, input int resp_delay, input logic [63:0] rdata,
    input  int extra_en_cycle,
    output int done_cyc, output int valid_cycles,
    output logic [63:0] o_addr, output logic [7:0] o_strb,
    output logic [63:0] o_wdata, output logic o_write, output logic stable);
    int rdy_wait;
    int resp_wait;
    logic accepted;
    rdy_wait = 0; resp_wait = 0; accepted = 1'b0;
    done_cyc = -1; valid_cycles = 0; stable = 1'b1;
    o_addr = '0; o_strb = '0; o_wdata = '0; o_write = 1'b0;
    alu_result = addr; store_data = sdata; is_load = ld; is_store = st;
    funct3 = f3; rd_in = rd; reg_write_in = rw; mem_enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      mem_enable = 1'b0; dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
      dcache_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (c == extra_en_cycle) begin
        mem_enable = 1'b1; alu_result = 64'h5555_0000; is_load = 1'b1; is_store = 1'b0;
      end
      if (mem_done) begin
        done_cyc = c;
        break;
      end
      if (dcache_req_valid) begin
        if (valid_cycles == 0) begin
          o_addr = dcache_req_addr; o_strb = dcache_req_wstrb;
          o_wdata = dcache_req_wdata; o_write = dcache_req_write;
        end else if (o_addr !== dcache_req_addr || o_strb !== dcache_req_wstrb ||
                     o_wdata !== dcache_req_wdata || o_write !== dcache_req_write) begin
          stable = 1'b0;
        end
        valid_cycles++;
        if (rdy_wait >= ready_delay) begin
          dcache_req_ready = 1'b1; accepted = 1'b1;
        end else begin
          rdy_wait++;
        end
      end else if (accepted) begin
        if (resp_wait >= resp_delay) begin
          dcache_resp_valid = 1'b1; dcache_resp_rdata = rdata;
        end else begin
          resp_wait++;
        end
      end
    end
    mem_enable = 1'b0; dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dcache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %0b want 0", dcache_req_valid); end
    checks++; if (mem_data_out !== 64'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", mem_data_out); end
    checks++; if (rd_out !== 5'd0 || reg_write_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_tags got rd=%0d rw=%0b want 0/0", rd_out, reg_write_out); end
    checks++; if (mem_done !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_busy got %0b/%0b want 0/0", mem_done, mem_busy); end
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %0b want 0", mem_fault); end
`endif
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %0b want 0", mem_busy); end
  endtask

  task automatic test_pass_through();
    int dc, vc; logic [63:0] a, w; logic [7:0] s; logic wr, stb;
    do_access(64'h1234, 64'd0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 0, 0, 64'd0, -1, dc, vc, a, s, w, wr, stb);
    checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL pass_done_cycle got %0d want 1", dc); end
    checks++; if (vc !== 0) begin errors++; $display("[TB] FAIL pass_no_req got %0d valid cycles want 0", vc); end
    checks++; if (mem_data_out !== 64'h1234) begin errors++; $display("[TB] FAIL pass_data got %h want 1234", mem_data_out); end
    checks++; if (rd_out !== 5'd5 || reg_write_out !== 1'b1) begin errors++; $display("[TB] FAIL pass_tags got rd=%0d rw=%0b want 5/1", rd_out, reg_write_out); end
    @(negedge clk);
    checks++; if (mem_done !== 1'b0 || mem_data_out !== 64'h1234) begin errors++; $display("[TB] FAIL pass_hold got done=%0b data=%h want 0/1234", mem_done, mem_data_out); end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  f3;
    logic [63:0] rdata;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
  } load_vec_t;

  task automatic test_loads();
    load_vec_t lv[9];
    int dc, vc; logic [63:0] a, w; logic [7:0] s; logic wr, stb;
    lv[0] = '{64'h1003, 3'b000, 64'h0000_0000_80FF_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF80};
    lv[1] = '{64'h1002, 3'b000, 64'h0000_0000_80FF_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF};
    lv[2] = '{64'h1002, 3'b100, 64'h0000_0000_80FF_0000, 64'h1000, 64'h0000_0000_0000_00FF};
    lv[3] = '{64'h1001, 3'b000, 64'h0000_0000_80FF_0000, 64'h1000, 64'h0000_0000_0000_0000};
    lv[4] = '{64'h1006, 3'b001, 64'h8001_0000_0000_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_8001};
    lv[5] = '{64'h1006, 3'b101, 64'h8001_0000_0000_0000, 64'h1000, 64'h0000_0000_0000_8001};
    lv[6] = '{64'h1004, 3'b010, 64'h8000_0000_0000_0000, 64'h1000, 64'hFFFF_FFFF_8000_0000};
    lv[7] = '{64'h1004, 3'b110, 64'h8000_0000_0000_0000, 64'h1000, 64'h0000_0000_8000_0000};
    lv[8] = '{64'h1008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h1008, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 9; i++) begin
      do_access(lv[i].addr, 64'd0, 1'b1, 1'b0, lv[i].f3, 5'(i + 1), 1'b1, 0, 0, lv[i].rdata, -1, dc, vc, a, s, w, wr, stb);
      checks++; if (dc !== 3) begin errors++; $display("[TB] FAIL load%0d_done_cycle got %0d want 3", i, dc); end
      checks++; if (a !== lv[i].exp_addr || wr !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_req got addr=%h write=%0b want %h/0", i, a, wr, lv[i].exp_addr); end
      checks++; if (mem_data_out !== lv[i].exp_data) begin errors++; $display("[TB] FAIL load%0d_data got %h want %h", i, mem_data_out, lv[i].exp_data); end
      checks++; if (rd_out !== 5'(i + 1) || reg_write_out !== 1'b1) begin errors++; $display("[TB] FAIL load%0d_tags got rd=%0d rw=%0b want %0d/1", i, rd_out, reg_write_out, i + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_stores();
    int dc, vc; logic [63:0] a, w; logic [7:0] s; logic wr, stb;
    do_access(64'h2006, 64'hABCD, 1'b0, 1'b1, 3'b001, 5'd9, 1'b1, 0, 0, 64'd0, -1, dc, vc, a, s, w, wr, stb);
    checks++; if (dc !== 3) begin errors++; $display("[TB] FAIL sh_done_cycle got %0d want 3", dc); end
    checks++; if (a !== 64'h2000 || wr !== 1'b1) begin errors++; $display("[TB] FAIL sh_req got addr=%h write=%0b want 2000/1", a, wr); end
    checks++; if (s !== 8'hC0) begin errors++; $display("[TB] FAIL sh_wstrb got %h want c0", s); end
    checks++; if (w !== 64'hABCD_0000_0000_0000) begin errors++; $display("[TB] FAIL sh_wdata got %h want abcd000000000000", w); end
    checks++; if (reg_write_out !== 1'b0 || mem_data_out !== 64'd0) begin errors++; $display("[TB] FAIL sh_writeback got rw=%0b data=%h want 0/0", reg_write_out, mem_data_out); end
    @(negedge clk);
    do_access(64'h2008, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 3'b011, 5'd3, 1'b1, 0, 0, 64'd0, -1, dc, vc, a, s, w, wr, stb);
    checks++; if (s !== 8'hFF || w !== 64'h1122_3344_5566_7788 || a !== 64'h2008) begin errors++; $display("[TB] FAIL sd_req got strb=%h wdata=%h addr=%h want ff/1122334455667788/2008", s, w, a); end
    @(negedge clk);
    do_access(64'h1002, 64'hFFFF, 1'b1, 1'b1, 3'b100, 5'd7, 1'b1, 0, 0, 64'h0000_0000_80FF_0000, -1, dc, vc, a, s, w, wr, stb);
    checks++; if (wr !== 1'b0 || mem_data_out !== 64'hFF || reg_write_out !== 1'b1) begin errors++; $display("[TB] FAIL both_as_load got write=%0b data=%h rw=%0b want 0/ff/1", wr, mem_data_out, reg_write_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc, vc; logic [63:0] a, w; logic [7:0] s; logic wr, stb;
    do_access(64'h4010, 64'd0, 1'b1, 1'b0, 3'b011, 5'd11, 1'b1, 3, 1, 64'hCAFE_F00D_1234_5678, 3, dc, vc, a, s, w, wr, stb);
    checks++; if (vc !== 4) begin errors++; $display("[TB] FAIL bp_valid_cycles got %0d want 4", vc); end
    checks++; if (stb !== 1'b1) begin errors++; $display("[TB] FAIL bp_fields_stable got %0b want 1", stb); end
    checks++; if (dc !== 7) begin errors++; $display("[TB] FAIL bp_done_cycle got %0d want 7", dc); end
    checks++; if (mem_data_out !== 64'hCAFE_F00D_1234_5678 || a !== 64'h4010) begin errors++; $display("[TB] FAIL bp_data got %h addr=%h want cafef00d12345678/4010", mem_data_out, a); end
    @(negedge clk);
    checks++; if (mem_busy !== 1'b0 || dcache_req_valid !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("[TB] FAIL bp_enable_ignored got busy=%0b valid=%0b done=%0b want 0/0/0", mem_busy, dcache_req_valid, mem_done); end
  endtask

  task automatic test_reset_in_wait();
    alu_result = 64'h5000; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b011;
    rd_in = 5'd4; reg_write_in = 1'b1; mem_enable = 1'b1;
    @(negedge clk);
    mem_enable = 1'b0; dcache_req_ready = 1'b1;
    @(negedge clk);
    dcache_req_ready = 1'b0;
    checks++; if (mem_busy !== 1'b1 || dcache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_state got busy=%0b valid=%0b want 1/0", mem_busy, dcache_req_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; dcache_resp_valid = 1'b1; dcache_resp_rdata = 64'h7777_7777_7777_7777;
    checks++; if (mem_busy !== 1'b0 || mem_done !== 1'b0 || dcache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_idle got busy=%0b done=%0b valid=%0b want 0/0/0", mem_busy, mem_done, dcache_req_valid); end
    checks++; if (mem_data_out !== 64'd0 || rd_out !== 5'd0 || reg_write_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_outputs got data=%h rd=%0d rw=%0b want 0/0/0", mem_data_out, rd_out, reg_write_out); end
    @(negedge clk);
    dcache_resp_valid = 1'b0;
    checks++; if (mem_done !== 1'b0 || mem_busy !== 1'b0 || mem_data_out !== 64'd0) begin errors++; $display("[TB] FAIL rst_wait_resp_dropped got done=%0b busy=%0b data=%h want 0/0/0", mem_done, mem_busy, mem_data_out); end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misaligned();
    alu_result = 64'h3002; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    rd_in = 5'd6; reg_write_in = 1'b1; mem_enable = 1'b1;
    @(negedge clk);
    mem_enable = 1'b0;
    checks++; if (mem_done !== 1'b1 || mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL trap_done_fault got done=%0b fault=%0b want 1/1", mem_done, mem_fault); end
    checks++; if (dcache_req_valid !== 1'b0 || reg_write_out !== 1'b0) begin errors++; $display("[TB] FAIL trap_no_req got valid=%0b rw=%0b want 0/0", dcache_req_valid, reg_write_out); end
    @(negedge clk);
    checks++; if (mem_fault !== 1'b0 || dcache_req_valid !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL trap_after got fault=%0b valid=%0b busy=%0b want 0/0/0", mem_fault, dcache_req_valid, mem_busy); end
  endtask
`else
  task automatic test_misaligned();
    int dc, vc; logic [63:0] a, w; logic [7:0] s; logic wr, stb;
    do_access(64'h3006, 64'h1122_3344, 1'b0, 1'b1, 3'b010, 5'd2, 1'b1, 0, 0, 64'd0, -1, dc, vc, a, s, w, wr, stb);
    checks++; if (vc !== 1 || a !== 64'h3000) begin errors++; $display("[TB] FAIL mis_sw_req got valid_cycles=%0d addr=%h want 1/3000", vc, a); end
    checks++; if (s !== 8'hC0 || w !== 64'h3344_0000_0000_0000) begin errors++; $display("[TB] FAIL mis_sw_lanes got strb=%h wdata=%h want c0/3344000000000000", s, w); end
    @(negedge clk);
    do_access(64'h3006, 64'd0, 1'b1, 1'b0, 3'b010, 5'd2, 1'b1, 0, 0, 64'hAABB_CCDD_0000_0000, -1, dc, vc, a, s, w, wr, stb);
    checks++; if (dc !== 3 || mem_data_out !== 64'h0000_0000_0000_AABB) begin errors++; $display("[TB] FAIL mis_lw_data got done=%0d data=%h want 3/000000000000aabb", dc, mem_data_out); end
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1; mem_enable = 1'b0; alu_result = '0; store_data = '0;
    is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000; rd_in = 5'd0; reg_write_in = 1'b0;
    dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_resp_rdata = '0;
    test_reset();
    test_pass_through();
    test_loads();
    test_stores();
    test_back_to_back();
    test_reset_in_wait();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
